// File: rtl/cp0_unit_if.sv
// rtl/cp0_unit_if.sv - M-stage exception/CP0 access bundle between pipeline and cp0_unit
interface cp0_unit_if;
   logic [5:0]  Exception;
   logic [31:0] PCM;
   logic        BDM;
   logic        ValidM;
   logic [5:0]  HWInt;
   logic [4:0]  CP0Addr;
   logic [31:0] CP0WD;
   logic        CP0WE;
   logic        ERET;
   logic [31:0] CP0RD;
   logic        GeneralFlush;
   logic        NPCSel;
   logic [31:0] NPCOut;
   logic [31:0] EPCOut;

   modport master (
      output Exception, PCM, BDM, ValidM, HWInt, CP0Addr, CP0WD, CP0WE, ERET,
      input  CP0RD, GeneralFlush, NPCSel, NPCOut, EPCOut
   );

   modport slave (
      input  Exception, PCM, BDM, ValidM, HWInt, CP0Addr, CP0WD, CP0WE, ERET,
      output CP0RD, GeneralFlush, NPCSel, NPCOut, EPCOut
   );
endinterface

// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - trap decision, SR/Cause/EPC/PrID, mfc0/mtc0/eret service
// Optional Count/Compare timer on HWInt[5] when CP0_COUNT_EN is defined.
module cp0_unit #(
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [31:0] PRID_VAL   = 32'h0000_0000
) (
   input logic        clock,
   input logic        reset,
   cp0_unit_if.slave  bus
);

   localparam logic [0:0] MODE_USER   = 1'b0;
   localparam logic [0:0] MODE_KERNEL = 1'b1;

   logic [5:0]  im;
   logic        exl;
   logic        ie;
   logic        bd;
   logic [5:0]  ip;
   logic [4:0]  exc_code;
   logic [31:0] epc;

   logic [5:0]  hw_eff;
   logic        int_req;
   logic        exc_req;
   logic        take;
   logic        mtc0;
   logic        wr_sr;
   logic        wr_epc;
   logic [31:0] pc_word;
   logic        unused_ok;

`ifdef CP0_COUNT_EN
   logic [31:0] count;
   logic [31:0] compare;
   logic        timer_pend;

   assign hw_eff = bus.HWInt | {timer_pend, 5'b0_0000};
`else
   assign hw_eff = bus.HWInt;
`endif

   assign int_req = (|(hw_eff & im)) & ie & ~exl & bus.ValidM;
   assign exc_req = bus.Exception[5] & ~exl & bus.ValidM;
   assign take    = int_req | exc_req;
   // A trap in the same cycle swallows any mtc0, so all writes are gated by ~take.
   assign mtc0    = bus.CP0WE & ~take;
   assign wr_sr   = mtc0 & (bus.CP0Addr == 5'd12);
   assign wr_epc  = mtc0 & (bus.CP0Addr == 5'd14);
   assign pc_word = {bus.PCM[31:2], 2'b00};
   assign unused_ok = ^bus.PCM[1:0];

   assign bus.GeneralFlush = take;
   assign bus.NPCSel       = take | bus.ERET;
   assign bus.NPCOut       = take ? HANDLER_PC : epc;
   assign bus.EPCOut       = epc;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         im       <= 6'd0;
         exl      <= MODE_USER;
         ie       <= 1'b0;
         bd       <= 1'b0;
         ip       <= 6'd0;
         exc_code <= 5'd0;
         epc      <= 32'd0;
      end else begin
         ip <= hw_eff;
         if (take) begin
            exl      <= MODE_KERNEL;
            exc_code <= int_req ? 5'd0 : bus.Exception[4:0];
            bd       <= bus.BDM;
            // EPC points at the branch when the faulting instruction sits in its delay slot.
            epc      <= bus.BDM ? (pc_word - 32'd4) : pc_word;
         end else begin
            if (wr_sr) begin
               im  <= bus.CP0WD[15:10];
               exl <= bus.CP0WD[1];
               ie  <= bus.CP0WD[0];
            end
            if (wr_epc)
               epc <= {bus.CP0WD[31:2], 2'b00};
            if (bus.ERET)
               exl <= MODE_USER;
         end
      end
   end

`ifdef CP0_COUNT_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count      <= 32'd0;
         compare    <= 32'd0;
         timer_pend <= 1'b0;
      end else begin
         if (mtc0 && bus.CP0Addr == 5'd9)
            count <= bus.CP0WD;
         else
            count <= count + 32'd1;
         if (mtc0 && bus.CP0Addr == 5'd11) begin
            compare    <= bus.CP0WD;
            timer_pend <= 1'b0;
         end else if (count == compare && compare != 32'd0) begin
            timer_pend <= 1'b1;
         end
      end
   end
`endif

   always_comb begin
      bus.CP0RD = 32'd0;
      case (bus.CP0Addr)
`ifdef CP0_COUNT_EN
         5'd9:    bus.CP0RD = count;
         5'd11:   bus.CP0RD = compare;
`endif
         5'd12:   bus.CP0RD = {16'd0, im, 8'd0, exl, ie};
         5'd13:   bus.CP0RD = {bd, 15'd0, ip, 3'd0, exc_code, 2'b00};
         5'd14:   bus.CP0RD = epc;
         5'd15:   bus.CP0RD = PRID_VAL;
         default: bus.CP0RD = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - scoreboard bench for cp0_unit (extra timer vectors when CP0_COUNT_EN is defined)
module tb_cp0_unit;

   localparam int S_RD = 0;
   localparam int S_FL = 1;
   localparam int S_NS = 2;
   localparam int S_NO = 3;
   localparam int S_EP = 4;

   typedef struct {
      int          sel;
      logic [31:0] exp;
      string       name;
   } exp_t;

   logic clock;
   logic reset;
   cp0_unit_if bus ();

   cp0_unit #(.HANDLER_PC(32'h0000_4180), .PRID_VAL(32'h0000_0000)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   exp_t        sb[$];
   exp_t        e;
   logic [31:0] act;
   int          checks = 0;
   int          passes = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) begin
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.sel)
            S_RD:    act = bus.CP0RD;
            S_FL:    act = {31'd0, bus.GeneralFlush};
            S_NS:    act = {31'd0, bus.NPCSel};
            S_NO:    act = bus.NPCOut;
            default: act = bus.EPCOut;
         endcase
         checks++;
         if (act === e.exp)
            passes++;
         else
            $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
   end

   task automatic chk(input int sel, input logic [31:0] exp, input string name);
      exp_t t;
      t.sel  = sel;
      t.exp  = exp;
      t.name = name;
      sb.push_back(t);
   endtask

   task automatic idle();
      bus.Exception = 6'h00;
      bus.PCM       = 32'd0;
      bus.BDM       = 1'b0;
      bus.ValidM    = 1'b1;
      bus.HWInt     = 6'd0;
      bus.CP0Addr   = 5'd0;
      bus.CP0WD     = 32'd0;
      bus.CP0WE     = 1'b0;
      bus.ERET      = 1'b0;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      idle();
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
      bus.CP0Addr = a;
      chk(S_RD, exp, name);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      bus.CP0Addr = a;
      bus.CP0WD   = d;
      bus.CP0WE   = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [4:0]  ra [4];
      logic [31:0] re [4];
      ra = '{5'd12, 5'd13, 5'd14, 5'd15};
      re = '{32'd0, 32'd0, 32'd0, 32'h0000_0000};
      reset = 1'b0;
      idle();
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;

      for (int i = 0; i < 4; i++) begin
         step(); rd(ra[i], re[i], "reset_rd"); chk(S_FL, 0, "reset_flush");
      end
      chk(S_NS, 0, "reset_npcsel");

      step(); bus.Exception = 6'h2C; bus.PCM = 32'h3010;
      chk(S_FL, 1, "ov_flush"); chk(S_NS, 1, "ov_npcsel"); chk(S_NO, 32'h4180, "ov_npcout");
      step(); rd(14, 32'h3010, "ov_epc"); chk(S_EP, 32'h3010, "ov_epcout"); chk(S_FL, 0, "ov_noflush");
      step(); rd(13, 32'h0000_0030, "ov_cause");
      step(); rd(12, 32'h0000_0002, "ov_sr");
      step(); wr(12, 32'd0);

      step(); bus.Exception = 6'h25; bus.BDM = 1'b1; bus.PCM = 32'h3010;
      chk(S_FL, 1, "bd_flush");
      step(); rd(14, 32'h300C, "bd_epc");
      step(); rd(13, 32'h8000_0014, "bd_cause");
      step(); wr(12, 32'd0);

      step(); wr(12, 32'h0000_0401); bus.ValidM = 1'b0; bus.HWInt = 6'b000001;
      chk(S_FL, 0, "int_wr_noflush");
      for (int i = 0; i < 2; i++) begin
         step(); bus.ValidM = 1'b0; bus.HWInt = 6'b000001; bus.Exception = 6'h2C;
         chk(S_FL, 0, "int_bubble_noflush");
      end
      step(); bus.HWInt = 6'b000001; bus.PCM = 32'h3020;
      chk(S_FL, 1, "int_flush"); chk(S_NO, 32'h4180, "int_npcout");
      step(); bus.HWInt = 6'b000001; rd(13, 32'h0000_0400, "int_cause"); chk(S_FL, 0, "int_exl_masks");
      step(); rd(14, 32'h3020, "int_epc");

      step(); bus.Exception = 6'h2A;
      chk(S_FL, 0, "exl_exc_ignored"); chk(S_NS, 0, "exl_exc_nosel");
      step(); bus.ERET = 1'b1;
      chk(S_NS, 1, "eret_npcsel"); chk(S_NO, 32'h3020, "eret_npcout"); chk(S_FL, 0, "eret_noflush");
      step(); rd(12, 32'h0000_0401, "eret_sr");
      step(); bus.ERET = 1'b1; bus.HWInt = 6'b000001;
      chk(S_FL, 1, "eret_int_flush"); chk(S_NO, 32'h4180, "eret_int_npcout");
      step(); rd(12, 32'h0000_0403, "eret_int_sr");

      step(); wr(12, 32'd0);
      step(); bus.Exception = 6'h2C; bus.PCM = 32'h5000; wr(14, 32'hDEAD_BEEF);
      chk(S_FL, 1, "wr_take_flush");
      step(); rd(14, 32'h5000, "wr_take_epc");
      step(); wr(13, 32'hFFFF_FFFF);
      step(); rd(13, 32'h0000_0030, "cause_ro");
      step(); wr(14, 32'h0000_1237);
      step(); rd(14, 32'h0000_1234, "epc_align");
      step(); bus.ERET = 1'b1; wr(14, 32'h0000_8888);
      chk(S_NO, 32'h1234, "eret_old_epc"); chk(S_NS, 1, "eret_wr_npcsel");
      step(); rd(14, 32'h0000_8888, "eret_wr_epc");
      step(); rd(12, 32'd0, "eret_wr_sr");
      step(); rd(5, 32'd0, "unimpl_rd");

`ifdef CP0_COUNT_EN
      step(); wr(11, 32'd5);
      step(); wr(9, 32'd0);
      step(); wr(12, 32'h0000_8001); bus.ValidM = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(); bus.ValidM = 1'b0; chk(S_FL, 0, "tmr_wait");
      end
      step(); chk(S_FL, 1, "tmr_flush");
      step(); rd(13, 32'h0000_8000, "tmr_cause");
      step(); wr(11, 32'd0);
      step();
      step(); rd(13, 32'd0, "tmr_cleared");
`else
      step(); wr(9, 32'h0000_0123);
      step(); rd(9, 32'd0, "count_absent");
      step(); wr(11, 32'h0000_0005);
      step(); rd(11, 32'd0, "compare_absent");
`endif

      step();
      @(negedge clock);
      #1;
      checks++;
      if (sb.size() == 0)
         passes++;
      else
         $display("FAIL sb_drain: got %0d expected 0", sb.size());
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Consumer end of the exception path.
- Takes the per-instruction exception code resolved at the M stage, plus external hardware interrupts.
- Decides whether a trap occurs, then updates SR/Cause/EPC. It drives GeneralFlush, which clears the exception pipeline and all stage registers, and supplies the handler or return PC.
- Also serves mfc0/mtc0/eret.

Parameters:
- HANDLER_PC, 32'h0000_4180, PC loaded on any trap.
- PRID_VAL, 32'h0000_0000, read-only value of PrID (reg 15).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; 0 resets all state.
- Exception  in  6  M-stage code; bit5=1 means exception present, [4:0]=ExcCode (PCAD/DRAD=6'h24, DWAD=6'h25, ILOP=6'h2A, OVER=6'h2C, NONE=6'h00).
- PCM  in  32  PC of the instruction in M.
- BDM  in  1  M instruction is in a branch delay slot.
- ValidM  in  1  M holds a real instruction, not a bubble.
- HWInt  in  6  external interrupt lines, level-sensitive.
- CP0Addr  in  5  mfc0/mtc0 register number.
- CP0WD  in  32  mtc0 write data.
- CP0WE  in  1  mtc0 in M.
- ERET  in  1  eret in M.
- CP0RD  out  32  combinational read data.
- GeneralFlush  out  1  trap taken this cycle.
- NPCSel  out  1  1 = redirect the fetch PC to NPCOut this cycle.
- NPCOut  out  32  HANDLER_PC on trap, EPC on eret.
- EPCOut  out  32  current EPC value.

Behaviour:
- Registers:
  - SR(12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
  - EPC(14): 32 bits, [1:0] forced to 0.
  - PrID(15).
  - Reads from any other address return 0.
- Reset (reset=0, async): SR=0, Cause=0, EPC=0. Outputs GeneralFlush=0, NPCSel=0.
- Interrupt request: IntReq = |(HWInt & SR.IM) & IE & !EXL & ValidM.
  - If ValidM=0, the interrupt is deferred (no trap) until a valid instruction reaches M.
- Exception request: ExcReq = Exception[5] & !EXL & ValidM.
  - With EXL=1, exceptions are ignored; the handler must not fault.
- Take = IntReq | ExcReq. Interrupt has priority over exception.
- Same cycle as Take (combinational): GeneralFlush=1, NPCSel=1, NPCOut=HANDLER_PC.
- Next rising edge after Take:
  - EXL<=1.
  - ExcCode<= IntReq ? 5'd0 : Exception[4:0].
  - BD<=BDM.
  - EPC<= BDM ? {PCM[31:2],2'b00}-4 : {PCM[31:2],2'b00}.
- Cause.IP <= HWInt every edge regardless of mask or EXL; it is a 1-cycle sampled copy.
- mtc0 (CP0WE=1, Take=0): writes to SR and EPC only; EPC write forces [1:0]=0. Writes to Cause, PrID, or unimplemented addresses are discarded.
- mtc0 with Take in the same cycle: the write is discarded and the trap updates win.
- ERET (Take=0):
  - Same cycle: NPCSel=1, NPCOut=EPC. If a mtc0 EPC write occurs in the same cycle, the old EPC is used.
  - Next edge: EXL<=0.
- ERET with Take in the same cycle: Take wins and EXL stays 1.
- CP0RD reflects register state before the current edge; there is no write-through bypass.
- State: EXL is the mode bit (USER: EXL=0, KERNEL: EXL=1).
  - USER→KERNEL on Take.
  - KERNEL→USER on ERET.
  - KERNEL→KERNEL on mtc0 SR with CP0WD[1]=1.
  - An mtc0 SR write may also clear EXL directly.

Optional Feature:
- Macro: CP0_COUNT_EN.
- When defined:
  - Count (reg 9) increments by 1 every clock, wrapping at 2^32.
  - Compare (reg 11) is writable by mtc0; writing Compare clears TimerPend.
  - TimerPend sets on the edge where Count==Compare and Compare!=0.
  - TimerPend is ORed into HWInt[5] for both IntReq and Cause.IP[15].
  - Count is also writable by mtc0; on a write cycle the written value replaces the increment.
  - Count, Compare, and TimerPend all reset to 0.
- When not defined: regs 9/11 read 0, writes to them are ignored, and there is no timer interrupt.

Test Plan:
- Reset pulse low, then mfc0 12/13/14/15 → 0, 0, 0, PRID_VAL; GeneralFlush=0.
- EXL=0, ValidM=1, Exception=6'h2C, PCM=32'h0000_3010, BDM=0 → same-cycle GeneralFlush=1 and NPCOut=32'h4180; next cycle EPC=32'h3010, Cause=32'h0000_0030, SR.EXL=1.
- Same as the previous case but BDM=1, Exception=6'h25 → EPC=32'h300C, Cause=32'h8000_0014.
- mtc0 SR=32'h0000_0401, HWInt=6'b000001 with ValidM=0 for 2 cycles, then ValidM=1 and PCM=32'h3020 → no flush while ValidM=0; flush on the first valid cycle; ExcCode=0, EPC=32'h3020.
- With EXL=1, Exception=6'h2A asserted → no flush. Then ERET → NPCSel=1, NPCOut=EPC, EXL=0 next cycle. ERET with a simultaneous enabled interrupt → flush, EXL stays 1.
- CP0_COUNT_EN build: mtc0 Compare=5, Count=0, SR=32'h0000_8001 → TimerPend after 5 increments; GeneralFlush=1 on the following valid cycle; Cause.IP[15]=1; writing Compare clears it.
